// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized CNN datapath: top-level state codes, image/kernel sizes
// and the input loader FSM encoding.
package bnn_pkg;

  localparam logic [2:0] s_IDLE    = 3'd0;
  localparam logic [2:0] s_LOAD    = 3'd1;
  localparam logic [2:0] s_LAYER_1 = 3'd2;
  localparam logic [2:0] s_LAYER_2 = 3'd3;
  localparam logic [2:0] s_LAYER_3 = 3'd4;

  localparam int N_PIX    = 784;
  localparam int N_WBITS  = 72;
  localparam int N_WBYTES = 9;
  localparam int IMG_W    = 28;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_PIX  = 3'd1,
    LD_WGT  = 3'd2,
    LD_CHK  = 3'd3,
    LD_DONE = 3'd4
  } ld_state_e;

  // Pixel binarization: a pixel is set when it reaches the threshold.
  function automatic logic binarize(input logic [7:0] value, input logic [7:0] thresh);
    return (value >= thresh);
  endfunction

endpackage

// File: rtl/input_loader.sv
// Streams 784 pixels then 9 weight bytes into the flat vectors used by layer one.
// Optional macro LOAD_CHECKSUM_EN adds a trailing mod-256 checksum beat and load_err reporting.
module input_loader
  import bnn_pkg::*;
#(
  parameter logic [7:0] PIX_THRESH = 8'd128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         state,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [0:N_PIX-1]   pixels,
  output logic [0:N_WBITS-1] weights,
  output logic               load_done,
  output logic               load_err
);

  localparam logic [9:0] PIX_LAST = 10'(N_PIX - 1);
  localparam logic [3:0] WGT_LAST = 4'(N_WBYTES - 1);

  ld_state_e          ld_state_r;
  ld_state_e          ld_next_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               entering_s;
  logic [9:0]         pix_cnt_r;
  logic [3:0]         wgt_cnt_r;
  logic [0:N_PIX-1]   pixels_r;
  logic [0:N_WBITS-1] weights_r;
  logic               load_done_r;

  assign accept_s   = in_valid && in_ready_s;
  assign entering_s = (ld_state_r == LD_IDLE) && (ld_next_s == LD_PIX);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state_r <= LD_IDLE;
    end else begin
      ld_state_r <= ld_next_s;
    end
  end

  // Next-state logic; leaving s_LOAD mid-stream aborts back to idle
  always_comb begin
    ld_next_s = ld_state_r;
    case (ld_state_r)
      LD_IDLE: begin
        if (state == s_LOAD) ld_next_s = LD_PIX;
        else                 ld_next_s = LD_IDLE;
      end
      LD_PIX: begin
        if (state != s_LOAD)                          ld_next_s = LD_IDLE;
        else if (accept_s && (pix_cnt_r == PIX_LAST)) ld_next_s = LD_WGT;
        else                                          ld_next_s = LD_PIX;
      end
      LD_WGT: begin
        if (state != s_LOAD) begin
          ld_next_s = LD_IDLE;
        end else if (accept_s && (wgt_cnt_r == WGT_LAST)) begin
`ifdef LOAD_CHECKSUM_EN
          ld_next_s = LD_CHK;
`else
          ld_next_s = LD_DONE;
`endif
        end else begin
          ld_next_s = LD_WGT;
        end
      end
      LD_CHK: begin
        if (state != s_LOAD) ld_next_s = LD_IDLE;
        else if (accept_s)   ld_next_s = LD_DONE;
        else                 ld_next_s = LD_CHK;
      end
      LD_DONE: begin
        if (state == s_IDLE) ld_next_s = LD_IDLE;
        else                 ld_next_s = LD_DONE;
      end
      default: ld_next_s = LD_IDLE;
    endcase
  end

  // Ready depends only on the FSM register and the top-level state, never on in_valid
  always_comb begin
    in_ready_s = 1'b0;
    case (ld_state_r)
      LD_PIX, LD_WGT, LD_CHK: begin
        if (state == s_LOAD) in_ready_s = 1'b1;
        else                 in_ready_s = 1'b0;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // Beat counters clear on every FSM transition and advance only on accepted beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_r <= 10'd0;
      wgt_cnt_r <= 4'd0;
    end else if (ld_next_s != ld_state_r) begin
      pix_cnt_r <= 10'd0;
      wgt_cnt_r <= 4'd0;
    end else if (accept_s && (ld_state_r == LD_PIX)) begin
      pix_cnt_r <= pix_cnt_r + 10'd1;
    end else if (accept_s && (ld_state_r == LD_WGT)) begin
      wgt_cnt_r <= wgt_cnt_r + 4'd1;
    end
  end

  // Vector capture; weight bytes land MSB first so in_data[7] is the lowest index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixels_r  <= '0;
      weights_r <= '0;
    end else if (accept_s && (ld_state_r == LD_PIX)) begin
      pixels_r[pix_cnt_r] <= binarize(in_data, PIX_THRESH);
    end else if (accept_s && (ld_state_r == LD_WGT)) begin
      weights_r[{wgt_cnt_r, 3'b000} +: 8] <= in_data;
    end
  end

  // load_done tracks entry into DONE, so it rises with the final beat's edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_done_r <= 1'b0;
    end else begin
      load_done_r <= (ld_next_s == LD_DONE);
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [7:0] sum_r;
  logic       load_err_r;

  // Running mod-256 sum of pixel and weight bytes, compared against the trailing beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r      <= 8'd0;
      load_err_r <= 1'b0;
    end else if (entering_s) begin
      sum_r      <= 8'd0;
      load_err_r <= 1'b0;
    end else if (accept_s && ((ld_state_r == LD_PIX) || (ld_state_r == LD_WGT))) begin
      sum_r <= sum_r + in_data;
    end else if (accept_s && (ld_state_r == LD_CHK)) begin
      load_err_r <= (in_data != sum_r);
    end
  end

  assign load_err = load_err_r;
`else
  logic unused_s;
  assign unused_s = entering_s;
  assign load_err = 1'b0;
`endif

  assign in_ready  = in_ready_s;
  assign pixels    = pixels_r;
  assign weights   = weights_r;
  assign load_done = load_done_r;

endmodule

// File: tb/tb_input_loader.sv
// Randomized self-checking bench for input_loader; the expected vectors come from an
// array model that replays accepted stream bytes through the binarize/pack rules.
module tb_input_loader;
  import bnn_pkg::*;

`ifdef LOAD_CHECKSUM_EN
  localparam int NB = 794;
`else
  localparam int NB = 793;
`endif

  logic          clk;
  logic          rst;
  logic [2:0]    state;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [0:783]  pixels;
  logic [0:71]   weights;
  logic          load_done;
  logic          load_err;

  int n_checks;
  int n_errors;

  logic [7:0]   stim [0:793];
  logic [0:783] exp_pix;
  logic [0:71]  exp_w;
  logic         db;
  logic         any_ready;

  input_loader dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pixels   (pixels),
    .weights  (weights),
    .load_done(load_done),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [783:0] got, input logic [783:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream content: mode 0 = alternating 200/50 pixels and 0xA5 weights, else random
  task automatic gen_stim(input int mode);
    logic [7:0] s;
    for (int k = 0; k < 793; k++) begin
      if (mode == 0) stim[k] = (k < 784) ? ((k % 2 == 0) ? 8'd200 : 8'd50) : 8'hA5;
      else           stim[k] = 8'($urandom_range(0, 255));
    end
    s = 8'd0;
    for (int k = 0; k < 793; k++) s = s + stim[k];
    stim[793] = s;
  endtask

  function automatic logic [7:0] stim_sum();
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 793; k++) s = s + stim[k];
    return s;
  endfunction

  // Reference model: the first n stream beats overwrite the image/kernel arrays
  task automatic model_apply(input int n);
    for (int k = 0; k < n && k < 793; k++) begin
      if (k < 784) exp_pix[k] = (stim[k] >= 8'd128);
      else for (int i = 0; i < 8; i++) exp_w[(k - 784) * 8 + i] = stim[k][7 - i];
    end
  endtask

  // Offers stim[0..nbeats-1] with random gaps; returns load_done sampled just before the last accepting edge
  task automatic run_load(input int nbeats, input int gap_pct, output logic done_before);
    int  idx;
    int  cyc;
    logic acc;
    idx = 0;
    cyc = 0;
    done_before = 1'bx;
    while (idx < nbeats && cyc < 5000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = stim[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc && idx == nbeats - 1) done_before = load_done;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("beats_accepted", idx, nbeats);
  endtask

  task automatic leave();
    state = s_IDLE;
    @(posedge clk);
    #1;
    check("leave_done_low", load_done, 1'b0);
  endtask

  task automatic check_vectors(input string tag);
    check({tag, "_pixels"}, pixels, exp_pix);
    check({tag, "_weights"}, weights, exp_w);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    state    = s_IDLE;
    in_valid = 1'b0;
    in_data  = 8'd0;
    exp_pix  = '0;
    exp_w    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixels", pixels, 784'd0);
    check("rst_weights", weights, 72'd0);
    check("rst_done", load_done, 1'b0);
    check("rst_err", load_err, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", in_ready, 1'b0);

    // Test 1: fixed pattern, valid held high
    gen_stim(0);
    state = s_LOAD;
    run_load(NB, 0, db);
    model_apply(NB);
    check("t1_done_before", db, 1'b0);
    check("t1_done", load_done, 1'b1);
    check("t1_ready_done", in_ready, 1'b0);
    check("t1_w0_7", weights[0:7], 8'b10100101);
    check("t1_p0_3", pixels[0:3], 4'b1010);
    check("t1_err", load_err, 1'b0);
    check_vectors("t1");
    leave();
    check_vectors("t1_retained");

    // Test 2: threshold boundary at the first two pixels
    gen_stim(1);
    stim[0] = 8'd127;
    stim[1] = 8'd128;
    stim[793] = stim_sum();
    state = s_LOAD;
    run_load(NB, 0, db);
    model_apply(NB);
    check("t2_p0", pixels[0], 1'b0);
    check("t2_p1", pixels[1], 1'b1);
    check("t2_done", load_done, 1'b1);
    check_vectors("t2");
    leave();

    // Test 3: 50% valid gaps, then extra beats in DONE must be refused
    gen_stim(0);
    state = s_LOAD;
    run_load(NB, 50, db);
    model_apply(NB);
    check("t3_done_before", db, 1'b0);
    check("t3_done", load_done, 1'b1);
    check_vectors("t3");
    any_ready = 1'b0;
    state = s_LAYER_1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      any_ready = any_ready | in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("t3_ready_in_done", any_ready, 1'b0);
    check("t3_done_held", load_done, 1'b1);
    check_vectors("t3_extra");
    leave();

    // Test 4: abort after 400 pixels, then a full reload
    gen_stim(1);
    state = s_LOAD;
    run_load(400, 0, db);
    model_apply(400);
    state = s_IDLE;
    @(posedge clk);
    #1;
    check("t4_abort_done", load_done, 1'b0);
    check("t4_abort_ready", in_ready, 1'b0);
    check_vectors("t4_partial");
    @(posedge clk);
    #1;
    gen_stim(1);
    state = s_LOAD;
    run_load(NB, 30, db);
    model_apply(NB);
    check("t4_done", load_done, 1'b1);
    check_vectors("t4");
    leave();

    // Test 5: asynchronous reset at beat 790
    gen_stim(1);
    state = s_LOAD;
    run_load(790, 0, db);
    rst = 1'b1;
    #1;
    check("t5_pixels", pixels, 784'd0);
    check("t5_weights", weights, 72'd0);
    check("t5_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("t5_done", load_done, 1'b0);
    check("t5_err", load_err, 1'b0);
    check("t5_ready_next", in_ready, 1'b0);
    exp_pix = '0;
    exp_w   = '0;
    state   = s_IDLE;
    rst     = 1'b0;
    @(posedge clk);
    #1;

`ifdef LOAD_CHECKSUM_EN
    // Test 6: checksum good, checksum off by one, cleared by next load entry
    gen_stim(1);
    state = s_LOAD;
    run_load(NB, 20, db);
    model_apply(NB);
    check("t6_good_err", load_err, 1'b0);
    check("t6_good_done", load_done, 1'b1);
    leave();
    gen_stim(1);
    stim[793] = stim_sum() + 8'd1;
    state = s_LOAD;
    run_load(NB, 0, db);
    model_apply(NB);
    check("t6_bad_err", load_err, 1'b1);
    check("t6_bad_done", load_done, 1'b1);
    check_vectors("t6");
    leave();
    check("t6_err_held_idle", load_err, 1'b1);
    state = s_LOAD;
    @(posedge clk);
    #1;
    check("t6_err_cleared", load_err, 1'b0);
    leave();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
